// File: rtl/game_pkg.sv
// Shared types and constants for the tic-tac-toe turn sequencer.
package game_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        X     = 2'b10,
        O     = 2'b11
    } cell_state_t;

    typedef enum logic [2:0] {
        START   = 3'd0,
        PLAYER1 = 3'd1,
        PLAYER2 = 3'd2,
        END     = 3'd3
    } state_t;

    localparam logic [3:0] NUM_CELLS = 4'd9;

endpackage

// File: rtl/game_controller_if.sv
// Move request / board write bundle between player logic, board memory and the turn controller.
interface game_controller_if;

    logic       isPlayer1Start;
    logic       playerWrite;
    logic [3:0] playerInput;
    logic       gameIsDone;
    logic [3:0] addr;
    logic [1:0] cellState;
    logic [2:0] outputState;

    modport master (
        output isPlayer1Start,
        output playerWrite,
        output playerInput,
        output gameIsDone,
        input  addr,
        input  cellState,
        input  outputState
    );

    modport slave (
        input  isPlayer1Start,
        input  playerWrite,
        input  playerInput,
        input  gameIsDone,
        output addr,
        output cellState,
        output outputState
    );

endinterface

// File: rtl/game_controller.sv
// Turn-sequencing FSM for 3x3 tic-tac-toe: alternates X/O moves and stops on gameIsDone.
module game_controller #(
    parameter logic [3:0] NUM_CELLS = game_pkg::NUM_CELLS
) (
    input  logic               ph1,
    input  logic               reset,
    game_controller_if.slave   bus
);

    import game_pkg::*;

    state_t      state_r;
    state_t      next_state_s;
    logic        valid_move_s;
    logic [3:0]  addr_s;
    cell_state_t cell_s;

    // A move only counts when the game is still live, so gameIsDone beats playerWrite.
    assign valid_move_s = bus.playerWrite && (bus.playerInput < NUM_CELLS) && !bus.gameIsDone;

    // Next-state and same-cycle board write outputs.
    always_comb begin
        next_state_s = START;
        addr_s       = 4'b0000;
        cell_s       = EMPTY;
        case (state_r)
            START: begin
                if (bus.isPlayer1Start) begin
                    next_state_s = PLAYER1;
                end else begin
                    next_state_s = PLAYER2;
                end
            end
            PLAYER1: begin
                addr_s = bus.playerInput;
                if (bus.gameIsDone) begin
                    next_state_s = END;
                end else if (valid_move_s) begin
                    next_state_s = PLAYER2;
                    cell_s       = X;
                end else begin
                    next_state_s = PLAYER1;
                end
            end
            PLAYER2: begin
                addr_s = bus.playerInput;
                if (bus.gameIsDone) begin
                    next_state_s = END;
                end else if (valid_move_s) begin
                    next_state_s = PLAYER1;
                    cell_s       = O;
                end else begin
                    next_state_s = PLAYER2;
                end
            end
            END: begin
                next_state_s = END;
            end
            default: begin
                next_state_s = START;
            end
        endcase
    end

    // State register; reset drops straight back to START without a clock.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_r <= START;
        end else begin
            state_r <= next_state_s;
        end
    end

    assign bus.outputState = state_r;
    assign bus.addr        = addr_s;
    assign bus.cellState   = cell_s;

endmodule

// File: tb/tb_game_controller.sv
// Directed self-checking bench for game_controller.
module tb_game_controller;

    logic ph1;
    logic reset;
    int   checks;
    int   failures;

    game_controller_if bus ();

    game_controller dut (
        .ph1   (ph1),
        .reset (reset),
        .bus   (bus)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [2:0] exp);
        chk(tag, {1'b0, bus.outputState}, {1'b0, exp});
    endtask

    task automatic chk_cell(input string tag, input logic [1:0] exp);
        chk(tag, {2'b00, bus.cellState}, {2'b00, exp});
    endtask

    task automatic edge_wait();
        @(posedge ph1);
        #1;
    endtask

    initial begin
        checks              = 0;
        failures            = 0;
        reset               = 1'b0;
        bus.isPlayer1Start  = 1'b1;
        bus.playerWrite     = 1'b0;
        bus.playerInput     = 4'd0;
        bus.gameIsDone      = 1'b0;

        // Held in reset for two clocks
        edge_wait();
        edge_wait();
        chk_state("rst_state", 3'd0);
        chk("rst_addr", bus.addr, 4'd0);
        chk_cell("rst_cell", 2'b00);

        reset = 1'b1;
        edge_wait();
        chk_state("start_to_p1", 3'd1);

        // X move at cell 4
        bus.playerWrite = 1'b1;
        bus.playerInput = 4'd4;
        #1;
        chk("p1_addr", bus.addr, 4'd4);
        chk_cell("p1_cell_x", 2'b10);
        edge_wait();
        chk_state("p1_to_p2", 3'd2);

        // O move at cell 8 (highest legal address)
        bus.playerInput = 4'd8;
        #1;
        chk("p2_addr", bus.addr, 4'd8);
        chk_cell("p2_cell_o", 2'b11);
        edge_wait();
        chk_state("p2_to_p1", 3'd1);

        // Idle turns hold
        bus.playerWrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge_wait();
            chk_state("idle_hold", 3'd1);
            chk_cell("idle_cell", 2'b00);
        end
        chk("idle_addr", bus.addr, 4'd8);

        // Reset between edges takes effect immediately
        #1;
        reset = 1'b0;
        #1;
        chk_state("async_rst1", 3'd0);
        bus.isPlayer1Start = 1'b0;
        #1;
        reset = 1'b1;
        edge_wait();
        chk_state("start_to_p2", 3'd2);

        // Invalid addresses 11 and 9: no write, no turn change
        bus.playerWrite = 1'b1;
        bus.playerInput = 4'd11;
        #1;
        chk_cell("inv11_cell", 2'b00);
        edge_wait();
        chk_state("inv11_hold", 3'd2);
        bus.playerInput = 4'd9;
        #1;
        chk_cell("inv9_cell", 2'b00);
        edge_wait();
        chk_state("inv9_hold", 3'd2);
        bus.playerInput = 4'd15;
        edge_wait();
        chk_state("inv15_hold", 3'd2);

        bus.playerInput = 4'd0;
        #1;
        chk_cell("p2_cell0_o", 2'b11);
        edge_wait();
        chk_state("p2_to_p1_b", 3'd1);

        // gameIsDone beats a valid-looking write
        bus.gameIsDone  = 1'b1;
        bus.playerInput = 4'd3;
        #1;
        chk_cell("done_cell", 2'b00);
        chk("done_addr", bus.addr, 4'd3);
        edge_wait();
        chk_state("p1_to_end", 3'd3);

        bus.gameIsDone     = 1'b0;
        bus.playerInput    = 4'd5;
        bus.isPlayer1Start = 1'b1;
        edge_wait();
        edge_wait();
        chk_state("end_hold", 3'd3);
        chk("end_addr", bus.addr, 4'd0);
        chk_cell("end_cell", 2'b00);

        // New game, then gameIsDone from PLAYER2
        reset = 1'b0;
        #1;
        chk_state("end_rst", 3'd0);
        reset = 1'b1;
        edge_wait();
        chk_state("restart_p1", 3'd1);
        bus.playerInput = 4'd2;
        edge_wait();
        chk_state("restart_p2", 3'd2);
        bus.gameIsDone = 1'b1;
        edge_wait();
        chk_state("p2_to_end", 3'd3);

        // Mid-game reset from PLAYER2
        bus.gameIsDone = 1'b0;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        edge_wait();
        edge_wait();
        chk_state("mid_p2", 3'd2);
        #2;
        reset = 1'b0;
        #1;
        chk_state("mid_rst_state", 3'd0);
        chk("mid_rst_addr", bus.addr, 4'd0);
        chk_cell("mid_rst_cell", 2'b00);
        #1;
        reset = 1'b1;
        edge_wait();
        chk_state("mid_rel_p1", 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
